// File: rtl/sm_accum.sv
// Frame accumulator for 36-bit sign-magnitude samples: sums ACC_LEN samples, saturating at 35'h7_ffff_ffff.
// Build option: define SM_ACCUM_STICKY_SAT_EN to freeze the accumulator for the rest of a frame once it saturates.
`timescale 1ns/1ps
module sm_accum #(
  parameter int ACC_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [35:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [35:0] out_data,
  input  logic        out_ready,
  output logic        out_sat
);

  // Handshake: a transfer happens on any rising edge where valid and ready are both 1;
  // in_ready and out_valid depend only on the FSM state and rst, never on the peer's signal.

  localparam int CW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);
  localparam logic [34:0] MAG_MAX = '1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          acc_sign;
  logic [34:0]   acc_mag;
  logic [CW-1:0] count;
  logic          sat;

  logic          in_sign;
  logic [34:0]   in_mag;
  logic [35:0]   wide_sum;
  logic          hold_acc;
  logic          sum_sign;
  logic [34:0]   sum_mag;
  logic          sum_sat;
  logic          in_fire;
  logic          out_fire;

  // Negative zero on the input is folded to +0 before any arithmetic.
  assign in_mag   = in_data[34:0];
  assign in_sign  = in_data[35] & (|in_data[34:0]);
  assign wide_sum = {1'b0, acc_mag} + {1'b0, in_mag};

`ifdef SM_ACCUM_STICKY_SAT_EN
  assign hold_acc = sat;
`else
  assign hold_acc = 1'b0;
`endif

  always_comb begin
    sum_sign = acc_sign;
    sum_mag  = acc_mag;
    sum_sat  = 1'b0;
    if (!hold_acc) begin
      if (acc_sign == in_sign) begin
        if (wide_sum[35]) begin
          sum_mag = MAG_MAX;
          sum_sat = 1'b1;
        end else begin
          sum_mag = wide_sum[34:0];
        end
      end else if (acc_mag > in_mag) begin
        sum_mag = acc_mag - in_mag;
      end else if (in_mag > acc_mag) begin
        sum_sign = in_sign;
        sum_mag  = in_mag - acc_mag;
      end else begin
        sum_sign = 1'b0;
        sum_mag  = '0;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == ACCUM) && !rst;
    out_valid = (state == HOLD) && !rst;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
    case (state)
      ACCUM: if (in_fire && (count == LAST)) state_nxt = HOLD;
      HOLD:  if (out_fire) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ACCUM;
      acc_sign <= 1'b0;
      acc_mag  <= '0;
      count    <= '0;
      sat      <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        acc_sign <= sum_sign;
        acc_mag  <= sum_mag;
        sat      <= sat | sum_sat;
        if (count == LAST) begin
          count    <= '0;
          out_data <= {sum_sign, sum_mag};
          out_sat  <= sat | sum_sat;
        end else begin
          count <= count + 1'b1;
        end
      end
      // Leaving HOLD starts a fresh frame; out_data keeps its last value but is not valid.
      if (out_fire) begin
        acc_sign <= 1'b0;
        acc_mag  <= '0;
        count    <= '0;
        sat      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sm_accum.sv
// Bench for sm_accum: four instances (ACC_LEN 4, 2, 3, 1) driven one at a time and
// checked against an integer-arithmetic reference model with a scoreboard queue.
`timescale 1ns/1ps
module tb_sm_accum;

`ifdef SM_ACCUM_STICKY_SAT_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  localparam longint MAXV = 64'h7_ffff_ffff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [3:0]  in_valid;
  logic [3:0]  out_ready;
  logic [35:0] in_data [4];
  wire  [3:0]  in_ready;
  wire  [3:0]  out_valid;
  wire  [3:0]  out_sat;
  wire  [35:0] out_data [4];

  sm_accum #(.ACC_LEN(4)) u_len4 (.clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_data(in_data[0]),
    .in_ready(in_ready[0]), .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]), .out_sat(out_sat[0]));
  sm_accum #(.ACC_LEN(2)) u_len2 (.clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_data(in_data[1]),
    .in_ready(in_ready[1]), .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]), .out_sat(out_sat[1]));
  sm_accum #(.ACC_LEN(3)) u_len3 (.clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_data(in_data[2]),
    .in_ready(in_ready[2]), .out_valid(out_valid[2]), .out_data(out_data[2]), .out_ready(out_ready[2]), .out_sat(out_sat[2]));
  sm_accum #(.ACC_LEN(1)) u_len1 (.clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_data(in_data[3]),
    .in_ready(in_ready[3]), .out_valid(out_valid[3]), .out_data(out_data[3]), .out_ready(out_ready[3]), .out_sat(out_sat[3]));

  // ---------------- scoreboard / reference model ----------------
  logic [36:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  longint m_acc [4];
  bit     m_sat [4];
  int     m_cnt [4];
  bit     rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int len_of(input int k);
    case (k)
      0: return 4;
      1: return 2;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic longint sm_to_int(input logic [35:0] d);
    longint m;
    m = longint'(d[34:0]);
    return d[35] ? -m : m;
  endfunction

  function automatic logic [35:0] int_to_sm(input longint v);
    longint a;
    a = (v < 0) ? -v : v;
    return {(v < 0), a[34:0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_acc[k] = 0;
      m_sat[k] = 1'b0;
      m_cnt[k] = 0;
    end
    exp_q.delete();
  endtask

  // Frame sum as a plain signed integer clamped to +/-MAXV.
  task automatic model_accept(input int k, input logic [35:0] d);
    longint s;
    if (!(STICKY && m_sat[k])) begin
      s = m_acc[k] + sm_to_int(d);
      if (s > MAXV) begin
        s = MAXV;
        m_sat[k] = 1'b1;
      end else if (s < -MAXV) begin
        s = -MAXV;
        m_sat[k] = 1'b1;
      end
      m_acc[k] = s;
    end
    m_cnt[k]++;
    if (m_cnt[k] == len_of(k)) begin
      exp_q.push_back({m_sat[k], int_to_sm(m_acc[k])});
      m_acc[k] = 0;
      m_sat[k] = 1'b0;
      m_cnt[k] = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [35:0] d);
    int budget;
    @(negedge clk);
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    #1;
    budget = 0;
    while (!in_ready[k] && budget < 100) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (budget == 100) check("push_timeout", in_ready[k], 1);
    else model_accept(k, d);
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    in_valid[k] = 1'b0;
    #1;
  endtask

  task automatic rand_sample(output logic [35:0] d);
    logic [63:0] r;
    logic [34:0] mag;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: mag = 35'($urandom_range(0, 20));
      1: mag = 35'(MAXV - longint'($urandom_range(0, 50)));
      2: mag = r[34:0];
      default: mag = '0;
    endcase
    d = {1'($urandom_range(0, 1)), mag};
  endtask

  // ---------------- output monitor ----------------
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      #2;
      for (int k = 0; k < 4; k++) begin
        if (out_valid[k]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_out_%0d", k), out_valid[k], 0);
          end else begin
            e = exp_q[0];
            check($sformatf("out_data_%0d", k), out_data[k], e[35:0]);
            check($sformatf("out_sat_%0d", k), out_sat[k], e[36]);
            if (out_ready[k]) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_ready)
        for (int k = 0; k < 4; k++) out_ready[k] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [35:0] d;
    logic [35:0] exp_sat3;
`ifdef SM_ACCUM_STICKY_SAT_EN
    exp_sat3 = {1'b0, 35'h7_ffff_ffff};
`else
    exp_sat3 = {1'b0, 35'h7_ffff_fff5};
`endif
    rst = 1'b1;
    in_valid = '0;
    out_ready = '1;
    for (int k = 0; k < 4; k++) in_data[k] = '0;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_ready, 4'h0);
    check("rst_out_valid", out_valid, 4'h0);
    check("rst_out_sat", out_sat, 4'h0);
    check("rst_out_data", {out_data[0], out_data[3]}, 72'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", in_ready, 4'hf);

    // +1 +2 -5 +7 -> +5, one-cycle output pulse
    push(0, {1'b0, 35'd1});
    push(0, {1'b0, 35'd2});
    push(0, {1'b1, 35'd5});
    push(0, {1'b0, 35'd7});
    idle(0);
    check("basic_valid", out_valid[0], 1);
    check("basic_data", out_data[0], {1'b0, 35'd5});
    check("basic_sat", out_sat[0], 0);
    check("basic_in_ready_hold", in_ready[0], 0);
    tick();
    check("basic_valid_drop", out_valid[0], 0);
    check("basic_ready_back", in_ready[0], 1);

    push(1, {1'b0, 35'h7_ffff_ffff});
    push(1, {1'b0, 35'd1});
    idle(1);
    check("sat2_data", out_data[1], {1'b0, 35'h7_ffff_ffff});
    check("sat2_flag", out_sat[1], 1);
    tick();

    push(2, {1'b0, 35'h7_ffff_ffff});
    push(2, {1'b0, 35'd1});
    push(2, {1'b1, 35'd10});
    idle(2);
    check("sat3_data", out_data[2], exp_sat3);
    check("sat3_flag", out_sat[2], 1);
    tick();

    push(1, {1'b1, 35'd9});
    push(1, {1'b0, 35'd9});
    idle(1);
    check("cancel_zero", out_data[1], 36'd0);
    tick();
    push(1, {1'b1, 35'd0});
    push(1, {1'b1, 35'd0});
    idle(1);
    check("negzero_frame", out_data[1], 36'd0);
    tick();

    // backpressure: HOLD for 5 cycles with in_valid asserted
    out_ready[1] = 1'b0;
    push(1, {1'b0, 35'd3});
    push(1, {1'b0, 35'd4});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid[1] = 1'b1;
      in_data[1]  = {4'($urandom), $urandom};
      #1;
      check("hold_valid", out_valid[1], 1);
      check("hold_data", out_data[1], {1'b0, 35'd7});
      check("hold_in_ready", in_ready[1], 0);
    end
    @(negedge clk);
    out_ready[1] = 1'b1;
    #1;
    check("xfer_in_ready", in_ready[1], 0);
    idle(1);
    check("after_xfer_valid", out_valid[1], 0);
    check("after_xfer_ready", in_ready[1], 1);
    push(1, {1'b1, 35'd2});
    push(1, {1'b0, 35'd10});
    idle(1);
    check("next_frame", out_data[1], {1'b0, 35'd8});
    tick();

    // reset mid-frame
    push(0, {1'b0, 35'd1});
    push(0, {1'b0, 35'd1});
    @(negedge clk);
    in_valid[0] = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_in_ready", in_ready[0], 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid[0], 0);
    for (int i = 0; i < 4; i++) push(0, {1'b0, 35'd1});
    idle(0);
    check("midrst_frame", out_data[0], {1'b0, 35'd4});
    tick();

    // reset during HOLD drops the pending sum
    out_ready[2] = 1'b0;
    for (int i = 0; i < 3; i++) push(2, {1'b0, 35'd6});
    idle(2);
    check("holdrst_pre_valid", out_valid[2], 1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    check("holdrst_valid_in_rst", out_valid[2], 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready[2] = 1'b1;
    #1;
    check("holdrst_valid_after", out_valid[2], 0);
    tick();
    check("holdrst_still_idle", out_valid[2], 0);

    // ACC_LEN=1 pass-through
    push(3, {1'b1, 35'd0});
    idle(3);
    check("len1_negzero", out_data[3], 36'd0);
    tick();
    push(3, {1'b1, 35'd77});
    idle(3);
    check("len1_pass", out_data[3], {1'b1, 35'd77});
    tick();

    // randomized frames with random gaps and random out_ready
    rand_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int s = 0; s < 8 * len_of(k); s++) begin
        if ($urandom_range(0, 3) == 0) idle(k);
        rand_sample(d);
        push(k, d);
      end
      idle(k);
      for (int b = 0; b < 200 && exp_q.size() != 0; b++) @(negedge clk);
      check($sformatf("drain_%0d", k), exp_q.size(), 0);
    end
    rand_ready = 1'b0;
    out_ready = '1;
    repeat (3) @(negedge clk);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm_accum.md
SM_ACCUM -- requirements
Module: sm_accum

Interface
REQ-001 SHALL have parameter ACC_LEN, default 16: samples summed per frame, legal range 1..1024.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-005 SHALL have port in_data  input  36  sign-magnitude sample: [35] sign (1 = negative), [34:0] magnitude.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port out_valid  output  1  frame sum is available.
REQ-008 SHALL have port out_data  output  36  frame sum in the same sign-magnitude format.
REQ-009 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-010 SHALL have port out_sat  output  1  saturation occurred during the reported frame; valid while out_valid=1.

Function
REQ-011 SHALL perform an input transfer when in_valid=1 and in_ready=1 in the same cycle, and an output transfer when out_valid=1 and out_ready=1 in the same cycle.
REQ-012 SHALL implement FSM states ACCUM and HOLD; reset enters ACCUM with accumulator=0, count=0 and sat flag=0.
REQ-013 In ACCUM: in_ready=1 and out_valid=0; each transfer updates the accumulator and increments the count.
REQ-014 When the ACC_LEN-th transfer occurs: the FSM SHALL enter HOLD, and out_data/out_sat SHALL be registered so out_valid=1 on the next cycle (1-cycle latency).
REQ-015 In HOLD: in_ready=0, out_valid=1, and out_data/out_sat SHALL stay stable until the output transfer.
REQ-016 After the output transfer, the FSM SHALL return to ACCUM on the next cycle with accumulator, count and sat flag cleared, so no input is accepted in the transfer cycle.
REQ-017 For same signs, the new magnitude SHALL be acc+in computed at 36 bits; the sign is kept.
REQ-018 On carry out of bit 34, the magnitude SHALL saturate to 35'h7_ffff_ffff and the sat flag SHALL be set.
REQ-019 For differing signs, the result SHALL be the larger magnitude minus the smaller, with the sign of the larger operand.
REQ-020 When differing-sign magnitudes are equal, the result SHALL be +0 (sign 0).
REQ-021 Negative zero on in_data SHALL be treated as +0, and out_data SHALL never present negative zero.
REQ-022 With ACC_LEN=1, every accepted sample SHALL pass to out_data unchanged, except that negative zero is normalized to +0.
REQ-023 While in ACCUM, in_valid=0 cycles SHALL leave all state unchanged; there is no timeout.

Reset
REQ-024 While rst=1 on a clock edge: out_valid=0, out_data=36'd0, out_sat=0, in_ready=0, accumulator=0, count=0 and FSM=ACCUM.
REQ-025 The cycle after rst deasserts, in_ready SHALL be 1.
REQ-026 Reset mid-frame or during HOLD SHALL discard the partial or pending sum without producing an output transfer.

Configuration
REQ-027 Macro SM_ACCUM_STICKY_SAT_EN SHALL select the saturation behaviour.
REQ-028 With SM_ACCUM_STICKY_SAT_EN defined: once saturated, the accumulator SHALL hold its sign and 35'h7_ffff_ffff for the rest of the frame, ignoring further samples (the count still advances).
REQ-029 Without SM_ACCUM_STICKY_SAT_EN: after saturation, later samples SHALL keep updating the accumulator per REQ-017..REQ-020, and out_sat SHALL still report that saturation occurred.

Verification
REQ-030 ACC_LEN=4, inputs +1, +2, -5, +7 back-to-back, out_ready=1 -> out_valid for exactly 1 cycle, 1 cycle after the 4th accept; out_data={0, 35'd5}; out_sat=0.
REQ-031 ACC_LEN=2, inputs +35'h7_ffff_ffff then +1 -> out_data={0, 35'h7_ffff_ffff}; out_sat=1.
REQ-032 ACC_LEN=3, inputs +35'h7_ffff_ffff, +1, -10 -> with macro: {0, 35'h7_ffff_ffff}, out_sat=1; without macro: {0, 35'h7_ffff_fff5}, out_sat=1.
REQ-033 ACC_LEN=2, inputs -9 then +9; then a frame of -0, -0 -> both frames give out_data=36'd0 (sign 0).
REQ-034 ACC_LEN=2 with out_ready held 0 for 5 cycles in HOLD -> out_data stable; in_ready=0; in_valid ignored; the next frame starts from 0 after out_ready=1.
REQ-035 ACC_LEN=4, rst pulsed after 2 accepts -> no output; the next 4 samples +1 each give out_data={0, 35'd4}.
